// File: rtl/servisia_mem_ctrl_if.sv
// Request/response handshake bundle for servisia_mem_ctrl.
// The core drives the master side, the controller the slave side.
interface servisia_mem_ctrl_if #(
    parameter int BEATS  = 4,
    parameter int ADDR_W = 20
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [ADDR_W-1:0]    req_addr_i;
    logic [8*BEATS-1:0]   req_wdata_i;
    logic [BEATS-1:0]     req_be_i;
    logic                 rsp_valid_o;
    logic [8*BEATS-1:0]   rsp_rdata_o;
    logic                 rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i,
        output req_wdata_i, req_be_i,
        input  req_ready_o, rsp_valid_o,
        input  rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i,
        input  req_wdata_i, req_be_i,
        output req_ready_o, rsp_valid_o,
        output rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/servisia_mem_ctrl.sv
// Word-to-byte external memory controller for async SRAM/flash.
// Banked chip selects, wait states, byte strobes, write protect.
module servisia_mem_ctrl #(
    parameter int BEATS       = 4,
    parameter int ADDR_W      = 20,
    parameter int BANK_BITS   = 1,
    parameter int WAIT_CYCLES = 1,
    parameter logic [(1<<BANK_BITS)-1:0] WRITE_MASK = 2'b10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    servisia_mem_ctrl_if.slave          bus,
    output logic [(1<<BANK_BITS)-1:0]   mem_ce_no,
    output logic                        mem_oe_no,
    output logic                        mem_we_no,
    output logic [ADDR_W-BANK_BITS-1:0] mem_addr_o,
    output logic [7:0]                  mem_dq_o,
    output logic                        mem_dq_oe_o,
    input  logic [7:0]                  mem_dq_i
);
    localparam int NB    = 1 << BANK_BITS;
    localparam int LOG2B = $clog2(BEATS);
    localparam int BW    = (LOG2B > 0) ? LOG2B : 1;
    localparam int MA_W  = ADDR_W - BANK_BITS;
    localparam int CW    = (WAIT_CYCLES > 0) ?
                           $clog2(WAIT_CYCLES + 1) : 1;
    localparam int DW    = 8 * BEATS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [BANK_BITS-1:0] bank_q, bank_d;
    logic [MA_W-1:0]      base_q, base_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [BEATS-1:0]     be_q, be_d;
    logic [DW-1:0]        rbuf_q, rbuf_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [NB-1:0]        ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;
    logic [MA_W-1:0]      maddr_q, maddr_d;
    logic [7:0]           dq_q, dq_d;
    logic                 dq_oe_q, dq_oe_d;

    logic [BW:0]          nxt;
    logic [BANK_BITS-1:0] acc_bank;
    logic                 misalign;
    logic                 wprot;

    // Lowest beat at or above start that carries data: every
    // beat for reads, only enabled bytes for writes.
    // Returns {found, index}.
    function automatic logic [BW:0] find_beat(
        input logic             wr,
        input logic [BEATS-1:0] en,
        input int               start
    );
        logic [BW:0] r;
        r = '0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (i >= start && (!wr || en[i])) begin
                r = {1'b1, BW'(i)};
            end
        end
        return r;
    endfunction

    assign acc_bank = bus.req_addr_i[ADDR_W-1 -: BANK_BITS];
    assign misalign = (bus.req_addr_i & ADDR_W'(BEATS - 1)) != '0;
    assign wprot    = bus.req_we_i && !WRITE_MASK[acc_bank];

    // Next-state and next-output computation for every register.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        bank_d      = bank_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rbuf_d      = rbuf_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        maddr_d     = maddr_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        nxt         = '0;

        unique case (state_q)
            S_IDLE: begin
                if (ready_q && bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    bank_d  = acc_bank;
                    base_d  = bus.req_addr_i[MA_W-1:0];
                    wdata_d = bus.req_wdata_i;
                    be_d    = bus.req_be_i;
                    if (misalign || wprot) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_we_i &&
                                 bus.req_be_i == '0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        nxt     = find_beat(bus.req_we_i,
                                            bus.req_be_i, 0);
                        state_d = S_SETUP;
                        beat_d  = nxt[BW-1:0];
                        ce_n_d  = ~(NB'(1) << acc_bank);
                        oe_n_d  = 1'b1;
                        we_n_d  = 1'b1;
                        maddr_d = bus.req_addr_i[MA_W-1:0] |
                                  MA_W'(nxt[BW-1:0]);
                        if (bus.req_we_i) begin
                            dq_d = bus.req_wdata_i[
                                8*int'(nxt[BW-1:0]) +: 8];
                        end
                        dq_oe_d = bus.req_we_i;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CW'(WAIT_CYCLES);
                oe_n_d  = we_q;
                we_n_d  = !we_q;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!we_q) begin
                        rbuf_d[8*int'(beat_q) +: 8] = mem_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                nxt = find_beat(we_q, be_q, int'(beat_q) + 1);
                if (nxt[BW]) begin
                    state_d = S_SETUP;
                    beat_d  = nxt[BW-1:0];
                    maddr_d = base_q | MA_W'(nxt[BW-1:0]);
                    if (we_q) begin
                        dq_d = wdata_q[8*int'(nxt[BW-1:0]) +: 8];
                    end
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    ce_n_d      = '1;
                    dq_oe_d     = 1'b0;
                    if (!we_q) begin
                        rdata_d = rbuf_q;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // Single register bank; reset aborts any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            bank_q      <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rbuf_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            ce_n_q      <= '1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            maddr_q     <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            bank_q      <= bank_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rbuf_q      <= rbuf_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            maddr_q     <= maddr_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign mem_ce_no       = ce_n_q;
    assign mem_oe_no       = oe_n_q;
    assign mem_we_no       = we_n_q;
    assign mem_addr_o      = maddr_q;
    assign mem_dq_o        = dq_q;
    assign mem_dq_oe_o     = dq_oe_q;
endmodule
